// File: rtl/matmul_sequencer_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM encoding, default
// widths and the derivation of the maximum matrix dimension.
package matmul_sequencer_pkg;

   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefBusWidth  = 64;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StLoad      = 3'd1,
      StCompute   = 3'd2,
      StDrain     = 3'd3,
      StWriteback = 3'd4,
      StDone      = 3'd5
   } state_e;

   // Number of elements that fit in one operand row.
   function automatic int unsigned calc_max_dim(int unsigned bus_width,
                                                int unsigned data_width);
      return bus_width / data_width;
   endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable up-counter with a terminal-count flag; it holds at the limit, so it
// never wraps.
module seq_counter #(
   parameter int unsigned Width = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [Width-1:0] load_value,
   input  logic             enable,
   input  logic [Width-1:0] limit,
   output logic [Width-1:0] count,
   output logic             tc
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (enable && !tc) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign tc    = (count_q == limit);
   assign count = count_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for a matrix-multiply PE array: arbitrates operand-memory
// bus access and steps through load, compute, drain and writeback phases.
module matmul_sequencer
   import matmul_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned BUS_WIDTH  = DefBusWidth,
   parameter int unsigned PE_LATENCY = 2,
   localparam int unsigned MAX_DIM   = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int unsigned AW        = $clog2(MAX_DIM),
   localparam int unsigned CW        = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [CW-1:0] dim_n_i,
   input  logic [CW-1:0] dim_k_i,
   input  logic          apb_req_i,
   output logic          apb_gnt_o,
   output logic [AW-1:0] a_addr_o,
   output logic [AW-1:0] b_addr_o,
   output logic          mem_we_o,
   output logic          pe_clear_o,
   output logic          pe_valid_o,
   output logic          res_we_o,
   output logic [AW-1:0] res_addr_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          error_o
);

   localparam int unsigned DrW       = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
   localparam int unsigned DrainLast = (PE_LATENCY > 0) ? PE_LATENCY - 1 : 0;

   state_e        state_q, state_d;
   logic [CW-1:0] dim_n_q, dim_n_d;
   logic [CW-1:0] dim_k_q, dim_k_d;
   logic          pending_q, pending_d;
   logic          error_q, error_d;
   logic          start_legal;

   logic [CW-1:0]  k_count, row_count;
   logic [DrW-1:0] drain_count;
   logic           k_tc, row_tc, drain_tc;
   logic           unused_bits;

   assign start_legal = (dim_n_i != '0) && (dim_n_i <= CW'(MAX_DIM)) &&
                        (dim_k_i != '0) && (dim_k_i <= CW'(MAX_DIM));

   // Each counter sits at zero outside its own phase, so entering a phase
   // always starts from a cleared count.
   seq_counter #(.Width(CW)) u_k_counter (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .load       (state_q != StCompute),
      .load_value ('0),
      .enable     (state_q == StCompute),
      .limit      (dim_k_q - CW'(1)),
      .count      (k_count),
      .tc         (k_tc)
   );

   seq_counter #(.Width(CW)) u_row_counter (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .load       (state_q != StWriteback),
      .load_value ('0),
      .enable     (state_q == StWriteback),
      .limit      (dim_n_q - CW'(1)),
      .count      (row_count),
      .tc         (row_tc)
   );

   seq_counter #(.Width(DrW)) u_drain_counter (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .load       (state_q != StDrain),
      .load_value ('0),
      .enable     (state_q == StDrain),
      .limit      (DrW'(DrainLast)),
      .count      (drain_count),
      .tc         (drain_tc)
   );

   assign unused_bits = ^{k_count[CW-1], row_count[CW-1], drain_count};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         dim_n_q   <= '0;
         dim_k_q   <= '0;
         pending_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dim_n_q   <= dim_n_d;
         dim_k_q   <= dim_k_d;
         pending_q <= pending_d;
         error_q   <= error_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dim_n_d   = dim_n_q;
      dim_k_d   = dim_k_q;
      pending_d = pending_q;
      error_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (start_legal) begin
                  dim_n_d = dim_n_i;
                  dim_k_d = dim_k_i;
                  // The bus keeps the memories while it asks; launch once it lets go.
                  if (apb_req_i) begin
                     pending_d = 1'b1;
                  end else begin
                     pending_d = 1'b0;
                     state_d   = StLoad;
                  end
               end else begin
                  error_d = 1'b1;
               end
            end else if (pending_q && !apb_req_i) begin
               pending_d = 1'b0;
               state_d   = StLoad;
            end
         end
         StLoad:      state_d = StCompute;
         StCompute:   if (k_tc) state_d = (PE_LATENCY == 0) ? StWriteback : StDrain;
         StDrain:     if (drain_tc) state_d = StWriteback;
         StWriteback: if (row_tc) state_d = StDone;
         StDone:      state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      apb_gnt_o  = 1'b0;
      a_addr_o   = '0;
      pe_clear_o = 1'b0;
      pe_valid_o = 1'b0;
      res_we_o   = 1'b0;
      res_addr_o = '0;
      busy_o     = 1'b1;
      done_o     = 1'b0;
      unique case (state_q)
         // Grant is gated by reset so every output is low while reset is held.
         StIdle: begin
            busy_o    = 1'b0;
            apb_gnt_o = apb_req_i & rst_ni;
         end
         StLoad:    pe_clear_o = 1'b1;
         StCompute: begin
            pe_valid_o = 1'b1;
            a_addr_o   = k_count[AW-1:0];
         end
         StDrain: ;
         StWriteback: begin
            res_we_o   = 1'b1;
            res_addr_o = row_count[AW-1:0];
         end
         StDone:  done_o = 1'b1;
         default: busy_o = 1'b0;
      endcase
   end

   assign b_addr_o = a_addr_o;
   assign mem_we_o = apb_gnt_o;
   assign error_o  = error_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: a cycle-offset reference model
// checked every cycle, plus literal traces for the key scenarios.
module tb_matmul_sequencer;

   localparam int DATA_WIDTH = 32;
   localparam int BUS_WIDTH  = 64;
   localparam int PE_LAT     = 2;
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
   localparam int AW         = $clog2(MAX_DIM);
   localparam int CW         = AW + 1;
   localparam int VW         = 8 + 3 * AW;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic [CW-1:0] dim_n_i = '0;
   logic [CW-1:0] dim_k_i = '0;
   logic          apb_req_i = 1'b0;
   logic          apb_gnt_o, mem_we_o, pe_clear_o, pe_valid_o, res_we_o;
   logic          busy_o, done_o, error_o;
   logic [AW-1:0] a_addr_o, b_addr_o, res_addr_o;
   logic [VW-1:0] act_vec;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   matmul_sequencer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH),
      .PE_LATENCY (PE_LAT)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .dim_n_i    (dim_n_i),
      .dim_k_i    (dim_k_i),
      .apb_req_i  (apb_req_i),
      .apb_gnt_o  (apb_gnt_o),
      .a_addr_o   (a_addr_o),
      .b_addr_o   (b_addr_o),
      .mem_we_o   (mem_we_o),
      .pe_clear_o (pe_clear_o),
      .pe_valid_o (pe_valid_o),
      .res_we_o   (res_we_o),
      .res_addr_o (res_addr_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   always #5 clk = ~clk;

   always_comb act_vec = {apb_gnt_o, mem_we_o, a_addr_o, b_addr_o, pe_clear_o, pe_valid_o,
                          res_we_o, res_addr_o, busy_o, done_o, error_o};

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit legal(int n, int k);
      return (n >= 1) && (n <= MAX_DIM) && (k >= 1) && (k <= MAX_DIM);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: an accepted operation is tracked by its offset from the
   // LOAD cycle; outputs follow from the phase lengths 1, K, PE_LAT, N, 1.
   int m_off = -1;
   int m_n = 0, m_k = 0, p_n = 0, p_k = 0;
   bit m_pend = 0, m_err = 0;

   always @(negedge clk) begin : cmp
      logic          e_gnt, e_clr, e_val, e_rwe, e_busy, e_done, e_err;
      logic [AW-1:0] e_a, e_ra;
      logic [VW-1:0] exp_vec;
      cyc++;
      e_gnt = 0; e_clr = 0; e_val = 0; e_rwe = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_a = '0; e_ra = '0;
      if (!rst_ni) begin
         m_off = -1; m_pend = 0; m_err = 0;
      end else if (m_off >= 0) begin
         e_busy = 1;
         if (m_off == 0) e_clr = 1;
         else if (m_off <= m_k) begin
            e_val = 1;
            e_a   = AW'(m_off - 1);
         end else if (m_off <= m_k + PE_LAT) begin
            e_busy = 1;
         end else if (m_off <= m_k + PE_LAT + m_n) begin
            e_rwe = 1;
            e_ra  = AW'(m_off - m_k - PE_LAT - 1);
         end else e_done = 1;
         m_off = e_done ? -1 : m_off + 1;
      end else begin
         e_gnt = apb_req_i;
         e_err = m_err;
         m_err = 0;
         if (start_i) begin
            if (!legal(int'(dim_n_i), int'(dim_k_i))) m_err = 1;
            else if (apb_req_i) begin
               m_pend = 1; p_n = int'(dim_n_i); p_k = int'(dim_k_i);
            end else begin
               m_pend = 0; m_off = 0; m_n = int'(dim_n_i); m_k = int'(dim_k_i);
            end
         end else if (m_pend && !apb_req_i) begin
            m_pend = 0; m_off = 0; m_n = p_n; m_k = p_k;
         end
      end
      exp_vec = {e_gnt, e_gnt, e_a, e_a, e_clr, e_val, e_rwe, e_ra, e_busy, e_done, e_err};
      chk($sformatf("model_cycle%0d", cyc), int'(act_vec), int'(exp_vec));
   end

   // {busy, clear, valid, a_addr, res_we, res_addr, done} for dims 2x2, offsets 0..9.
   logic [6:0] trace_exp [10] = '{7'b0000000, 7'b1100000, 7'b1010000, 7'b1011000,
                                  7'b1000000, 7'b1000000, 7'b1000100, 7'b1000110,
                                  7'b1000001, 7'b0000000};

   task automatic run_trace(input string nm);
      logic [6:0] act;
      dim_n_i = 2; dim_k_i = 2; start_i = 1;
      for (int off = 0; off < 10; off++) begin
         @(negedge clk);
         act = {busy_o, pe_clear_o, pe_valid_o, a_addr_o[0], res_we_o, res_addr_o[0], done_o};
         chk($sformatf("%s_off%0d", nm, off), int'(act), int'(trace_exp[off]));
         tick();
         start_i = 0;
      end
   endtask

   task automatic err_case(input int n, input int k, input string nm);
      dim_n_i = CW'(n); dim_k_i = CW'(k); start_i = 1;
      @(negedge clk);
      chk({nm, "_err_c0"}, int'(error_o), 0);
      tick();
      start_i = 0;
      @(negedge clk);
      chk({nm, "_err_c1"}, int'(error_o), 1);
      chk({nm, "_busy_c1"}, int'(busy_o), 0);
      tick();
      @(negedge clk);
      chk({nm, "_err_c2"}, int'(error_o), 0);
      chk({nm, "_busy_c2"}, int'(busy_o), 0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      int ndone;
      repeat (2) tick();
      chk("reset_outputs", int'(act_vec), 0);
      rst_ni = 1;
      tick();

      run_trace("basic");

      err_case(1, 0, "dimk0");
      err_case(3, 1, "dimn3");

      // Start while the bus holds the memories; release after three cycles.
      dim_n_i = 1; dim_k_i = 1; apb_req_i = 1; start_i = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c < 3) begin
            chk($sformatf("pend_gnt_c%0d", c), int'(apb_gnt_o), 1);
            chk($sformatf("pend_we_c%0d", c), int'(mem_we_o), 1);
         end else if (c == 3) chk("pend_gnt_c3", int'(apb_gnt_o), 0);
         else chk("pend_load_c4", int'(pe_clear_o), 1);
         tick();
         start_i = 0;
         if (c == 2) apb_req_i = 0;
      end
      repeat (10) tick();

      // Bus request raised mid-COMPUTE must wait for the first IDLE cycle.
      dim_n_i = 2; dim_k_i = 2; start_i = 1;
      tick();
      start_i = 0;
      repeat (2) tick();
      apb_req_i = 1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         chk("gnt_while_busy", int'(apb_gnt_o), 0);
         if (done_o) seen = 1;
         tick();
      end
      chk("done_seen", int'(seen), 1);
      @(negedge clk);
      chk("gnt_after_done", int'(apb_gnt_o), 1);
      chk("we_after_done", int'(mem_we_o), 1);
      tick();
      apb_req_i = 0;
      tick();

      // Asynchronous reset in the middle of COMPUTE.
      dim_n_i = 2; dim_k_i = 2; start_i = 1;
      tick();
      start_i = 0;
      repeat (2) tick();
      chk("busy_before_reset", int'(busy_o), 1);
      #2 rst_ni = 0;
      #1 chk("async_reset_outputs", int'(act_vec), 0);
      tick();
      rst_ni = 1;
      run_trace("after_reset");

      // A second start during WRITEBACK is ignored.
      dim_n_i = 1; dim_k_i = 1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         start_i = (c == 0 || c == 5);
         @(negedge clk);
         if (done_o) ndone++;
         if (c == 5) chk("restart_in_wb", int'(res_we_o), 1);
         tick();
      end
      start_i = 0;
      chk("single_done", ndone, 1);
      @(negedge clk);
      chk("idle_after_restart", int'(busy_o), 0);
      tick();

      for (int i = 0; i < 400; i++) begin
         start_i = ($urandom_range(0, 5) == 0);
         dim_n_i = CW'($urandom_range(0, 3));
         dim_k_i = CW'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) apb_req_i = ~apb_req_i;
         tick();
      end
      start_i = 0;
      apb_req_i = 0;
      repeat (20) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
